// File: rtl/sslp_elp_ctrl.sv
// Landing-pad expectation (ELP) controller for the SSLP forward-edge CFI path.
// Tracks whether the next instruction must be an LPAD and saves/restores ELP across traps.
module sslp_elp_ctrl #(
    parameter int unsigned NrCommitPorts = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     lp_enable_i,
    input  logic                     issue_ack_i,
    input  logic                     issue_is_indirect_i,
    input  logic [NrCommitPorts-1:0] commit_valid_i,
    input  logic [NrCommitPorts-1:0] commit_is_indirect_i,
    input  logic [NrCommitPorts-1:0] commit_is_lpad_i,
    input  logic                     trap_i,
    input  logic                     trap_to_s_i,
    input  logic                     mret_i,
    input  logic                     sret_i,
    output logic                     xLPAD_o,
    output logic                     issue_stall_o,
    output logic                     mpelp_o,
    output logic                     spelp_o
);

    localparam logic [1:0] NO_LP     = 2'b00;
    localparam logic [1:0] JUMP_PEND = 2'b01;
    localparam logic [1:0] LP_EXP    = 2'b10;

    logic [1:0] state_q, state_d;
    logic       mpelp_q, mpelp_d;
    logic       spelp_q, spelp_d;

    logic       anyIndirectCommit;
    logic       firstFound;
    logic       firstIsLpad;
    logic       firstIsIndirect;
    logic       elpNow;

    assign anyIndirectCommit = |(commit_valid_i & commit_is_indirect_i);
    assign elpNow            = (state_q == LP_EXP);

    // The oldest retiring instruction (lowest port) decides whether a pending LPAD was honoured.
    always_comb begin
        firstFound      = 1'b0;
        firstIsLpad     = 1'b0;
        firstIsIndirect = 1'b0;
        for (int unsigned k = 0; k < NrCommitPorts; k++) begin
            if (!firstFound && commit_valid_i[k]) begin
                firstFound      = 1'b1;
                firstIsLpad     = commit_is_lpad_i[k];
                firstIsIndirect = commit_is_indirect_i[k];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        mpelp_d = mpelp_q;
        spelp_d = spelp_q;

        if (trap_i) begin
            if (trap_to_s_i) begin
                spelp_d = elpNow;
            end else begin
                mpelp_d = elpNow;
            end
            state_d = NO_LP;
        end else if (mret_i) begin
            state_d = (mpelp_q && lp_enable_i) ? LP_EXP : NO_LP;
            mpelp_d = 1'b0;
        end else if (sret_i) begin
            state_d = (spelp_q && lp_enable_i) ? LP_EXP : NO_LP;
            spelp_d = 1'b0;
        end else begin
            case (state_q)
                NO_LP: begin
                    if (issue_ack_i && issue_is_indirect_i && lp_enable_i) begin
                        state_d = JUMP_PEND;
                    end
                end
                // A jump that commits alongside a mispredict flush still creates the expectation.
                JUMP_PEND: begin
                    if (anyIndirectCommit) begin
                        state_d = LP_EXP;
                    end else if (flush_i) begin
                        state_d = NO_LP;
                    end
                end
                // The expectation is architectural, so a flush on its own leaves it in place.
                LP_EXP: begin
                    if (!lp_enable_i) begin
                        state_d = NO_LP;
                    end else if (firstFound) begin
                        if (firstIsLpad) begin
                            state_d = NO_LP;
                        end else if (firstIsIndirect) begin
                            state_d = LP_EXP;
                        end else begin
                            state_d = NO_LP;
                        end
                    end
                end
                default: begin
                    state_d = NO_LP;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= NO_LP;
            mpelp_q <= 1'b0;
            spelp_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mpelp_q <= mpelp_d;
            spelp_q <= spelp_d;
        end
    end

    assign xLPAD_o       = (state_q == LP_EXP);
    assign issue_stall_o = (state_q == JUMP_PEND);
    assign mpelp_o       = mpelp_q;
    assign spelp_o       = spelp_q;

endmodule

// File: tb/tb_sslp_elp_ctrl.sv
// Scoreboard bench for sslp_elp_ctrl: each driven cycle queues the outputs the
// controller must show after the next rising edge as {xLPAD, stall, mpelp, spelp}.
module tb_sslp_elp_ctrl;

    logic       clk_i;
    logic       rst_ni;
    logic       flush_i;
    logic       lp_enable_i;
    logic       issue_ack_i;
    logic       issue_is_indirect_i;
    logic [1:0] commit_valid_i;
    logic [1:0] commit_is_indirect_i;
    logic [1:0] commit_is_lpad_i;
    logic       trap_i;
    logic       trap_to_s_i;
    logic       mret_i;
    logic       sret_i;
    logic       xLPAD_o;
    logic       issue_stall_o;
    logic       mpelp_o;
    logic       spelp_o;

    typedef struct {
        string      tag;
        logic [3:0] outs;
    } expect_t;

    expect_t expQueue[$];
    int      checkCount = 0;
    int      passCount  = 0;

    sslp_elp_ctrl #(.NrCommitPorts(2)) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .flush_i             (flush_i),
        .lp_enable_i         (lp_enable_i),
        .issue_ack_i         (issue_ack_i),
        .issue_is_indirect_i (issue_is_indirect_i),
        .commit_valid_i      (commit_valid_i),
        .commit_is_indirect_i(commit_is_indirect_i),
        .commit_is_lpad_i    (commit_is_lpad_i),
        .trap_i              (trap_i),
        .trap_to_s_i         (trap_to_s_i),
        .mret_i              (mret_i),
        .sret_i              (sret_i),
        .xLPAD_o             (xLPAD_o),
        .issue_stall_o       (issue_stall_o),
        .mpelp_o             (mpelp_o),
        .spelp_o             (spelp_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got xlpad/stall/mpelp/spelp=%b, want %b", tag, observed, expected);
        end
    endtask

    // Scoreboard consumer: compares the oldest expectation once the edge has settled.
    always @(posedge clk_i) begin
        #1;
        if (expQueue.size() > 0) begin
            expect_t e;
            e = expQueue.pop_front();
            checkOutput(e.tag, {xLPAD_o, issue_stall_o, mpelp_o, spelp_o}, e.outs);
        end
    end

    task automatic clearInputs();
        flush_i              = 1'b0;
        issue_ack_i          = 1'b0;
        issue_is_indirect_i  = 1'b0;
        commit_valid_i       = 2'b00;
        commit_is_indirect_i = 2'b00;
        commit_is_lpad_i     = 2'b00;
        trap_i               = 1'b0;
        trap_to_s_i          = 1'b0;
        mret_i               = 1'b0;
        sret_i               = 1'b0;
    endtask

    // Inputs are set by the caller beforehand; this queues the expectation and spends one cycle.
    task automatic applyStimulus(input string tag, input logic [3:0] expOuts);
        expect_t e;
        e.tag  = tag;
        e.outs = expOuts;
        expQueue.push_back(e);
        @(posedge clk_i);
        #2;
        clearInputs();
    endtask

    task automatic issueJump(input string tag, input logic [3:0] expOuts);
        issue_ack_i         = 1'b1;
        issue_is_indirect_i = 1'b1;
        applyStimulus(tag, expOuts);
    endtask

    task automatic commitJump(input string tag, input logic [1:0] port, input logic [3:0] expOuts);
        commit_valid_i       = port;
        commit_is_indirect_i = port;
        applyStimulus(tag, expOuts);
    endtask

    initial begin
        #20000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_ni      = 1'b0;
        lp_enable_i = 1'b1;
        clearInputs();
        #1;
        checkOutput("reset_state", {xLPAD_o, issue_stall_o, mpelp_o, spelp_o}, 4'b0000);
        repeat (2) @(posedge clk_i);
        #2;
        rst_ni = 1'b1;
        applyStimulus("idle_after_reset", 4'b0000);

        // Basic jump -> LPAD
        issueJump("jump_issue_stall", 4'b0100);
        applyStimulus("pend_hold1", 4'b0100);
        applyStimulus("pend_hold2", 4'b0100);
        commitJump("jump_commit_p0", 2'b01, 4'b1000);
        applyStimulus("lpexp_hold", 4'b1000);
        flush_i = 1'b1;
        applyStimulus("lpexp_flush_keeps", 4'b1000);
        commit_valid_i   = 2'b10;
        commit_is_lpad_i = 2'b10;
        applyStimulus("lpad_commit_p1", 4'b0000);

        // Mispredict kill, then jump commit racing the flush
        issueJump("kill_issue", 4'b0100);
        flush_i = 1'b1;
        applyStimulus("kill_flush", 4'b0000);
        issueJump("race_issue", 4'b0100);
        flush_i = 1'b1;
        commitJump("race_commit_flush", 2'b10, 4'b1000);

        // Trap to M saves ELP, MRET restores it
        trap_i = 1'b1;
        applyStimulus("trap_m_save", 4'b0010);
        applyStimulus("trap_m_hold", 4'b0010);
        mret_i = 1'b1;
        applyStimulus("mret_restore", 4'b1000);

        // Trap to S saves 1, a second S trap from NO_LP overwrites with 0
        trap_i      = 1'b1;
        trap_to_s_i = 1'b1;
        applyStimulus("trap_s_save1", 4'b0001);
        trap_i      = 1'b1;
        trap_to_s_i = 1'b1;
        applyStimulus("trap_s_save0", 4'b0000);
        issueJump("s_issue", 4'b0100);
        commitJump("s_commit", 2'b01, 4'b1000);
        trap_i      = 1'b1;
        trap_to_s_i = 1'b1;
        applyStimulus("trap_s_save_again", 4'b0001);
        lp_enable_i = 1'b0;
        sret_i      = 1'b1;
        applyStimulus("sret_disabled", 4'b0000);
        lp_enable_i = 1'b1;

        // Trap outranks a same-cycle jump commit
        issueJump("prio_issue", 4'b0100);
        trap_i = 1'b1;
        commit_valid_i       = 2'b01;
        commit_is_indirect_i = 2'b01;
        applyStimulus("prio_trap_over_commit", 4'b0000);

        // Lowest port decides in LP_EXP
        issueJump("order_issue1", 4'b0100);
        commitJump("order_commit1", 2'b01, 4'b1000);
        commit_valid_i       = 2'b11;
        commit_is_lpad_i     = 2'b01;
        commit_is_indirect_i = 2'b10;
        applyStimulus("order_lpad_first", 4'b0000);
        issueJump("order_issue2", 4'b0100);
        commitJump("order_commit2", 2'b01, 4'b1000);
        commit_valid_i       = 2'b11;
        commit_is_indirect_i = 2'b01;
        commit_is_lpad_i     = 2'b10;
        applyStimulus("order_jump_first", 4'b1000);
        commit_valid_i = 2'b01;
        applyStimulus("lpexp_non_lpad", 4'b0000);

        // Disabling checking drops an expectation and blocks new ones
        issueJump("dis_issue", 4'b0100);
        commitJump("dis_commit", 2'b01, 4'b1000);
        lp_enable_i = 1'b0;
        applyStimulus("lpexp_disable", 4'b0000);
        issueJump("disabled_issue", 4'b0000);
        applyStimulus("disabled_hold", 4'b0000);
        lp_enable_i = 1'b1;

        // Build LP_EXP with mpelp set, then reset asynchronously
        issueJump("rst_issue1", 4'b0100);
        commitJump("rst_commit1", 2'b01, 4'b1000);
        trap_i = 1'b1;
        applyStimulus("rst_trap_m", 4'b0010);
        issueJump("rst_issue2", 4'b0110);
        commitJump("rst_commit2", 2'b01, 4'b1010);
        #1;
        rst_ni = 1'b0;
        #1;
        checkOutput("async_reset", {xLPAD_o, issue_stall_o, mpelp_o, spelp_o}, 4'b0000);
        @(posedge clk_i);
        #2;
        rst_ni = 1'b1;
        applyStimulus("post_reset_idle", 4'b0000);

        repeat (2) @(posedge clk_i);
        if (expQueue.size() != 0) begin
            checkOutput("queue_drained", 4'(expQueue.size()), 4'd0);
        end
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/sslp_elp_ctrl.md
Name: sslp_elp_ctrl

Overview:
- Landing-pad expectation (ELP) controller for the SSLP forward-edge CFI path.
- Tracks whether the next instruction must be an LPAD.
- Drives xLPAD_i of the decode stage.
- Stalls decode→issue handoff while an indirect jump is in flight, so the decoder never sees a stale expectation.
- Saves ELP on traps and restores it on xRET, giving the CSR file its MPELP/SPELP values.

Parameters:
NrCommitPorts, 2, number of commit ports scanned each cycle

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active-low
flush_i  in  1  pipeline flush from controller (kills uncommitted instructions)
lp_enable_i  in  1  landing-pad checking enabled at current privilege (xenvcfg.LPE per priv)
issue_ack_i  in  1  decode entry 0 accepted by issue
issue_is_indirect_i  in  1  accepted entry is LP-relevant indirect jump (JALR/C.JR/C.JALR, rs1 not x1/x5/x7)
commit_valid_i  in  NrCommitPorts  commit port valid (instruction retires, no exception)
commit_is_indirect_i  in  NrCommitPorts  committing instruction is LP-relevant indirect jump
commit_is_lpad_i  in  NrCommitPorts  committing instruction is LPAD
trap_i  in  1  exception/interrupt taken this cycle
trap_to_s_i  in  1  trap target is S-mode (else M)
mret_i  in  1  MRET commits
sret_i  in  1  SRET commits
xLPAD_o  out  1  landing pad expected; to decoder xLPAD_i
issue_stall_o  out  1  block fetch_entry_ready / new decode handoff
mpelp_o  out  1  saved ELP for M-mode trap
spelp_o  out  1  saved ELP for S-mode trap

Behaviour:
- FSM states: NO_LP (00), JUMP_PEND (01), LP_EXP (10). Registers: state_q, mpelp_q, spelp_q.
- Reset: state_q=NO_LP, mpelp_q=0, spelp_q=0. All outputs 0.
- All outputs are registered-state decodes; zero combinational path from inputs:
  - xLPAD_o = (state_q==LP_EXP)
  - issue_stall_o = (state_q==JUMP_PEND)
  - mpelp_o = mpelp_q; spelp_o = spelp_q
- Transition priority per cycle, highest first:
  1. trap_i:
     - Save e = (state_q==LP_EXP).
     - If trap_to_s_i, spelp_q<=e; else mpelp_q<=e.
     - state→NO_LP.
     - Flush, commit and issue inputs are ignored that cycle.
  2. mret_i:
     - state→ (mpelp_q && lp_enable_i) ? LP_EXP : NO_LP.
     - mpelp_q<=0.
  3. sret_i:
     - Same rule using spelp_q; spelp_q<=0.
     - mret_i and sret_i never assert together; if they do, mret_i wins.
  4. NO_LP:
     - issue_ack_i && issue_is_indirect_i && lp_enable_i → JUMP_PEND.
     - With lp_enable_i=0, stay NO_LP.
  5. JUMP_PEND:
     - Any port k with commit_valid_i[k] && commit_is_indirect_i[k] → LP_EXP. This is checked before flush, so a jump that commits and flushes (mispredict) in the same cycle still yields LP_EXP.
     - Otherwise flush_i → NO_LP (jump was killed).
     - Otherwise hold.
  6. LP_EXP:
     - Scan ports in order 0..N-1; the first valid commit decides:
       - LPAD → NO_LP.
       - Indirect jump → stay LP_EXP.
       - Otherwise → NO_LP. Decoder already flagged a software-check exception on that instruction, which arrives as trap_i; it normally never commits.
     - flush_i alone does not clear LP_EXP: the expectation is architectural.
     - lp_enable_i falling → NO_LP.
- One jump in flight at most:
  - The stall is visible from the cycle after issue_ack_i.
  - The instruction decoded in the same cycle as the jump's ack is not yet handed off.
  - The controller asserts issue_stall_o before the next handoff can occur (one-cycle latency).
- Latency:
  - Issue of indirect jump → issue_stall_o high next cycle.
  - Jump commit → xLPAD_o high, stall low, next cycle.
  - LPAD commit → xLPAD_o low next cycle.
- Reset mid-operation: asynchronous return to reset values regardless of state.
- Illegal state encoding 11 → NO_LP next cycle.

Test Plan:
1. Basic jump→LPAD:
   - Stimulus: lp_enable_i=1, issue_ack_i=1 with issue_is_indirect_i=1 at cycle 0.
   - Required: issue_stall_o=1 at cycle 1.
   - Stimulus: commit_valid_i=01, commit_is_indirect_i=01 at cycle 3.
   - Required: xLPAD_o=1, stall=0 at cycle 4.
   - Stimulus: commit LPAD on port 1 at cycle 6.
   - Required: xLPAD_o=0 at cycle 7.
2. Mispredict kill:
   - Stimulus: JUMP_PEND, then flush_i=1 with no commit.
   - Required: next cycle stall=0, xLPAD_o=0.
   - Stimulus: repeat with commit_is_indirect_i=1 and flush_i=1 in the same cycle.
   - Required: xLPAD_o=1.
3. Trap save/restore M:
   - Stimulus: LP_EXP, trap_i=1, trap_to_s_i=0.
   - Required: mpelp_o=1, xLPAD_o=0.
   - Stimulus: later mret_i=1.
   - Required: xLPAD_o=1, mpelp_o=0.
4. Trap save/restore S:
   - Stimulus: NO_LP, trap_i=1, trap_to_s_i=1.
   - Required: spelp_o=0.
   - Stimulus: LP_EXP, trap_i=1, trap_to_s_i=1, then sret_i=1 with lp_enable_i=0.
   - Required: xLPAD_o=0, spelp_o=0.
5. Priority:
   - Stimulus: JUMP_PEND; trap_i=1 and commit indirect in the same cycle.
   - Required: state NO_LP, saved ELP=0.
   - Stimulus: LP_EXP; commit_valid_i=11, port0 LPAD, port1 indirect.
   - Required: NO_LP.
6. Disabled/reset:
   - Stimulus: lp_enable_i=0; issue indirect.
   - Required: issue_stall_o stays 0.
   - Stimulus: assert rst_ni=0 while in LP_EXP with mpelp_q=1.
   - Required: all outputs 0 immediately.
